contador_parametrizado: RTL and testbench
=========================================

// Module: contador_parametrizado
// PURPOSE
//  Parametrised run/stop timer for the timer-and-control path. Counts clock cycles from a
//  start pulse up to a run-time limit, raises a threshold flag at a run-time threshold, and
//  either saturates at the limit (non-recycling) or wraps to zero (recycling), selected per run.
//  In recycling mode it also keeps a saturating count of completed periods.
// PARAMETERS
//  WIDTH   8  bit width of count, limit and thresh
//  WRAP_W  4  bit width of the wrap_count period counter (saturates at 2**WRAP_W-1)
// PORTS
//  clock       in   1        single clock, all logic on posedge
//  reset       in   1        synchronous, active-low; sampled on posedge clock only
//  start       in   1        start or restart a run; latches limit, thresh and recycle
//  clear       in   1        abort to IDLE
//  pause       in   1        hold count while high (RUN only)
//  recycle     in   1        0 = saturate at limit, 1 = wrap at limit (latched at start)
//  limit       in   WIDTH    terminal count (latched at start)
//  thresh      in   WIDTH    threshold for q (latched at start)
//  count       out  WIDTH    current count
//  q           out  1        threshold flag
//  done        out  1        high while in DONE (count held at limit)
//  wrap_pulse  out  1        one-cycle pulse on each wrap (recycling mode)
//  wrap_count  out  WRAP_W   completed periods since start, saturating
//  busy        out  1        high in RUN
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; count, q, done, wrap_pulse, wrap_count, busy all 0;
//    latched limit/thresh/recycle registers 0. Reset beats every other input.
//  - Priority at each edge: reset > clear > start > pause > advance.
//  - States, 2-bit encoding: IDLE=0, RUN=1, DONE=2. Code 3 is unused and recovers to IDLE.
//  - IDLE: count held at 0, q=0. start -> RUN with count=0 and wrap_count=0.
//    The latches take limit, thresh and recycle on the same edge.
//  - RUN, pause=1: count, q and wrap_count held; wrap_pulse=0.
//  - RUN, pause=0, count<limit_r: count <= count+1.
//  - RUN, pause=0, count==limit_r, recycle_r=0: count stays limit_r. state -> DONE.
//  - RUN, pause=0, count==limit_r, recycle_r=1: count <= 0, wrap_pulse <= 1 for that cycle.
//    wrap_count <= wrap_count+1 unless already all-ones. State stays RUN.
//  - Non-recycling entry into DONE: the edge that makes count==limit_r also sets state=DONE.
//    done is therefore high in the same cycle count first shows limit_r.
//    With limit_r==0, start leads to DONE on the next edge.
//  - DONE: count held at limit_r, done=1. start restarts (-> RUN, count 0). clear -> IDLE.
//  - q is registered. q==1 iff state!=IDLE and the registered count >= thresh_r.
//    Non-recycling: once high, q stays high until clear, start or reset.
//    Recycling: q drops on the wrap edge when thresh_r>0.
//    thresh_r > limit_r: q never asserts. thresh_r==0: q=1 from the first RUN cycle.
//  - start in RUN or DONE: restart. count=0, wrap_count=0, wrap_pulse=0, new operands latched.
//    q is re-evaluated against the new thresh_r.
//  - clear in any state: IDLE, all outputs 0. start+clear on the same edge: clear wins.
//  - Changes to limit/thresh/recycle inputs outside the start edge have no effect.
//  - busy = (state==RUN). wrap_pulse is never high for two consecutive cycles unless limit_r==0.
//  - All arithmetic is unsigned WIDTH-bit. count never exceeds limit_r and never wraps
//    through 2**WIDTH.
// TESTING
//  1. Reset held low 3 cycles with start=1 -> all outputs 0, state IDLE.
//     Release reset, nothing else applied -> count stays 0.
//  2. recycle=0, limit=7, thresh=4, start at edge 0:
//     - q=1 after edge 4, done=1 with count=7 after edge 7.
//     - count stays 7 for 10 further cycles.
//  3. recycle=1, limit=3, thresh=2, 12 cycles:
//     - count sequence 0,1,2,3,0,1,...
//     - wrap_pulse high each time count is 0 after a wrap.
//     - q high at count 2 and 3.
//     - wrap_count=3 after 12 edges.
//     - with WRAP_W=2, running longer keeps wrap_count at 3.
//  4. recycle=0, limit=9: pause high for 5 cycles at count=5 -> count and q held.
//     Release pause -> done appears 5 cycles later than in an unpaused run.
//  5. Mid-run events, limit=9:
//     - start at count=6 -> count 0 next cycle with new limit/thresh applied.
//     - clear and start on the same edge -> IDLE.
//     - reset low at count=6 -> all outputs 0 next cycle.
//  6. Corners:
//     - limit=0, recycle=0 -> done after one edge.
//     - limit=0, recycle=1 -> wrap_pulse high every cycle.
//     - thresh=200, limit=100 -> q never rises.
//     - limit=255, WIDTH=8 -> count stops at 255, no overflow.

Source files
------------

// File: rtl/contador_parametrizado.sv
// Run/stop cycle timer: counts from a start pulse up to a latched limit, flags a latched
// threshold, and either stops at the limit or wraps while tallying completed periods.
module contador_parametrizado #(
  parameter int WIDTH  = 8,
  parameter int WRAP_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              pause,
  input  logic              recycle,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  thresh,
  output logic [WIDTH-1:0]  count,
  output logic              q,
  output logic              done,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    limit_q, limit_d;
  logic [WIDTH-1:0]    thresh_q, thresh_d;
  logic                recycle_q, recycle_d;
  logic                q_q, q_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0]   wrap_count_q, wrap_count_d;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    limit_d      = limit_q;
    thresh_d     = thresh_q;
    recycle_d    = recycle_q;
    wrap_pulse_d = 1'b0;
    wrap_count_d = wrap_count_q;

    if (clear) begin
      state_d      = IDLE;
      count_d      = '0;
      wrap_count_d = '0;
    end else if (start) begin
      state_d      = RUN;
      count_d      = '0;
      wrap_count_d = '0;
      limit_d      = limit;
      thresh_d     = thresh;
      recycle_d    = recycle;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
        end
        RUN: begin
          if (!pause) begin
            if (count_q == limit_q) begin
              if (recycle_q) begin
                count_d      = '0;
                wrap_pulse_d = 1'b1;
                if (wrap_count_q != '1) begin
                  wrap_count_d = wrap_count_q + 1'b1;
                end
              end else begin
                state_d = DONE;
              end
            end else begin
              count_d = count_q + 1'b1;
              // Entering DONE on the same edge that reaches the limit keeps done aligned with count
              if (!recycle_q && (count_d == limit_q)) begin
                state_d = DONE;
              end
            end
          end
        end
        DONE: begin
          count_d = limit_q;
        end
        default: begin
          state_d      = IDLE;
          count_d      = '0;
          wrap_count_d = '0;
        end
      endcase
    end

    q_d = (state_d != IDLE) && (count_d >= thresh_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      limit_q      <= '0;
      thresh_q     <= '0;
      recycle_q    <= 1'b0;
      q_q          <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      limit_q      <= limit_d;
      thresh_q     <= thresh_d;
      recycle_q    <= recycle_d;
      q_q          <= q_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign count      = count_q;
  assign q          = q_q;
  assign done       = (state_q == DONE);
  assign busy       = (state_q == RUN);
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_count = wrap_count_q;

endmodule

// File: tb/tb_contador_parametrizado.sv
// Self-checking bench for contador_parametrizado: directed scenarios plus a random phase,
// every cycle compared against a behavioural timer model.
module tb_contador_parametrizado;

  localparam int WIDTH  = 8;
  localparam int WRAP_W = 4;
  localparam int WMAX   = (1 << WRAP_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              clear = 1'b0;
  logic              pause = 1'b0;
  logic              recycle = 1'b0;
  logic [WIDTH-1:0]  limit = '0;
  logic [WIDTH-1:0]  thresh = '0;
  logic [WIDTH-1:0]  count;
  logic              q;
  logic              done;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              busy;

  int checks = 0;
  int failures = 0;

  int mCount, mLimit, mThresh, mWrapCount;
  bit mRec, mRunning, mFinished, mWrapPulse;

  contador_parametrizado #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .pause(pause),
    .recycle(recycle), .limit(limit), .thresh(thresh), .count(count), .q(q),
    .done(done), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Timer rules applied to one clock edge, in priority order reset > clear > start > run
  task automatic modelEdge(input bit rstN, input bit st, input bit clr, input bit pa,
                           input bit rec, input int lim, input int thr);
    if (!rstN) begin
      mRunning = 0; mFinished = 0; mCount = 0; mWrapCount = 0; mWrapPulse = 0;
      mLimit = 0; mThresh = 0; mRec = 0;
    end else if (clr) begin
      mRunning = 0; mFinished = 0; mCount = 0; mWrapCount = 0; mWrapPulse = 0;
    end else if (st) begin
      mLimit = lim; mThresh = thr; mRec = rec;
      mRunning = 1; mFinished = 0; mCount = 0; mWrapCount = 0; mWrapPulse = 0;
    end else begin
      mWrapPulse = 0;
      if (mRunning && !pa) begin
        if (mCount < mLimit) begin
          mCount = mCount + 1;
          if (!mRec && mCount == mLimit) begin
            mRunning = 0; mFinished = 1;
          end
        end else if (mRec) begin
          mCount = 0;
          mWrapPulse = 1;
          if (mWrapCount < WMAX) mWrapCount = mWrapCount + 1;
        end else begin
          mRunning = 0; mFinished = 1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    chk("count", count, mCount);
    chk("q", q, ((mRunning || mFinished) && (mCount >= mThresh)) ? 1 : 0);
    chk("done", done, mFinished);
    chk("busy", busy, mRunning);
    chk("wrap_pulse", wrap_pulse, mWrapPulse);
    chk("wrap_count", wrap_count, mWrapCount);
  endtask

  task automatic applyStimulus(input bit rstN, input bit st, input bit clr, input bit pa,
                               input bit rec, input int lim, input int thr);
    reset = rstN; start = st; clear = clr; pause = pa; recycle = rec;
    limit = WIDTH'(lim); thresh = WIDTH'(thr);
    @(posedge clock);
    modelEdge(rstN, st, clr, pa, rec, lim, thr);
    #1;
    checkOutput();
  endtask

  task automatic idleStep();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit sawQ;
    int lim, thr;

    // Reset held with start asserted, then released with nothing applied
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1, 9, 2);
    chk("reset_count", count, 0);
    for (int i = 0; i < 3; i++) idleStep();
    chk("idle_count", count, 0);

    // Non-recycling run, limit 7 threshold 4
    applyStimulus(1, 1, 0, 0, 0, 7, 4);
    for (int e = 1; e <= 7; e++) begin
      idleStep();
      if (e == 3) chk("t2_q_before", q, 0);
      if (e == 4) chk("t2_q_edge4", q, 1);
      if (e == 6) chk("t2_done_before", done, 0);
    end
    chk("t2_done", done, 1);
    chk("t2_count", count, 7);
    for (int i = 0; i < 10; i++) idleStep();
    chk("t2_hold", count, 7);

    // Recycling run, limit 3 threshold 2, then saturate the period counter
    applyStimulus(1, 1, 0, 0, 1, 3, 2);
    for (int e = 1; e <= 12; e++) begin
      idleStep();
      chk("t3_seq", count, e % 4);
      chk("t3_pulse", wrap_pulse, (e % 4 == 0) ? 1 : 0);
    end
    chk("t3_wraps", wrap_count, 3);
    for (int i = 0; i < 60; i++) idleStep();
    chk("t3_sat", wrap_count, WMAX);

    // Pause for five cycles at count 5
    applyStimulus(1, 1, 0, 0, 0, 9, 7);
    for (int i = 0; i < 5; i++) idleStep();
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0);
    chk("t4_held", count, 5);
    chk("t4_q_held", q, 0);
    for (int e = 11; e <= 14; e++) begin
      idleStep();
      if (e == 13) chk("t4_done_early", done, 0);
    end
    chk("t4_done_late", done, 1);

    // Mid-run restart, clear+start together, reset mid-run
    applyStimulus(1, 1, 0, 0, 0, 9, 3);
    for (int i = 0; i < 6; i++) idleStep();
    applyStimulus(1, 1, 0, 0, 0, 5, 1);
    chk("t5_restart", count, 0);
    idleStep();
    chk("t5_new_thresh", q, 1);
    for (int i = 0; i < 4; i++) idleStep();
    chk("t5_new_limit", done, 1);
    applyStimulus(1, 1, 1, 0, 0, 9, 3);
    chk("t5_clear_wins", busy, 0);
    applyStimulus(1, 1, 0, 0, 0, 9, 3);
    for (int i = 0; i < 6; i++) idleStep();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    chk("t5_reset", count, 0);

    // Corner cases
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    idleStep();
    chk("t6_lim0_done", done, 1);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      idleStep();
      chk("t6_lim0_pulse", wrap_pulse, 1);
    end
    applyStimulus(1, 1, 0, 0, 0, 100, 200);
    sawQ = 0;
    for (int i = 0; i < 110; i++) begin
      idleStep();
      sawQ = sawQ | q;
    end
    chk("t6_no_q", sawQ, 0);
    applyStimulus(1, 1, 0, 0, 0, 255, 250);
    for (int i = 0; i < 260; i++) idleStep();
    chk("t6_lim255", count, 255);
    chk("t6_lim255_done", done, 1);

    // Random phase against the model
    for (int i = 0; i < 400; i++) begin
      lim = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 12);
      thr = $urandom_range(0, 14);
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 1), lim, thr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
